// File: rtl/ps2_focus_router.sv
// ps2_focus_router: decodes the PS/2 scancode stream (make, break, E0-extended),
// owns keyboard focus across up to four entry FSMs and forwards clean make
// codes to the focused one.
// Optional build macro: PS2_ROUTER_REPEAT_FILTER_EN adds a typematic repeat filter.
module ps2_focus_router #(
    parameter int NUM_FIELDS     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic [7:0]            data,
    input  logic                  data_en,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic [NUM_FIELDS-1:0] field_en,
    output logic                  focus_valid
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] K_EXT = 8'hE0;
    localparam logic [7:0] K_BRK = 8'hF0;
    localparam logic [7:0] K_F1  = 8'h05;
    localparam logic [7:0] K_F2  = 8'h06;
    localparam logic [7:0] K_F3  = 8'h04;
    localparam logic [7:0] K_F4  = 8'h0C;
    localparam logic [7:0] K_TAB = 8'h0D;
    localparam logic [7:0] K_ESC = 8'h76;

    localparam logic [1:0] LAST_IDX  = 2'(NUM_FIELDS - 1);
    localparam logic [2:0] NF3       = 3'(NUM_FIELDS);

    logic [1:0] state, state_nxt;
    logic       focus_on, focus_nxt;
    logic [1:0] focus_idx, idx_nxt;
    logic       make_stb, brk_stb, accept, expire, fwd;
    logic       sel_hit;
    logic [1:0] sel_idx;
    logic       is_repeat;

    // Decoder next state; only a strobed byte moves it.
    always_comb begin
        state_nxt = state;
        if (data_en) begin
            case (state)
                ST_IDLE:    if (data == K_EXT) state_nxt = ST_EXT;
                            else if (data == K_BRK) state_nxt = ST_BRK;
                ST_BRK:     state_nxt = ST_IDLE;
                ST_EXT:     state_nxt = (data == K_BRK) ? ST_EXT_BRK : ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    assign make_stb = data_en && (state == ST_IDLE) && (data != K_EXT) && (data != K_BRK);
    assign brk_stb  = data_en && (state == ST_BRK);

`ifdef PS2_ROUTER_REPEAT_FILTER_EN
    logic [7:0] last_make;

    // 0 in last_make means no key is held, so it never matches as a repeat.
    assign is_repeat = (last_make != 8'h00) && (data == last_make);

    // Remember the held key; its break releases it.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)                     last_make <= 8'h00;
        else if (make_stb && !is_repeat) last_make <= data;
        else if (brk_stb && is_repeat)   last_make <= 8'h00;
    end
`else
    assign is_repeat = 1'b0;
`endif

    assign accept = make_stb && !is_repeat;

    // Map the function keys to a field index.
    always_comb begin
        sel_hit = 1'b1;
        sel_idx = 2'd0;
        case (data)
            K_F1:    sel_idx = 2'd0;
            K_F2:    sel_idx = 2'd1;
            K_F3:    sel_idx = 2'd2;
            K_F4:    sel_idx = 2'd3;
            default: sel_hit = 1'b0;
        endcase
    end

    // Classify an accepted make; a make beats a simultaneous timeout.
    always_comb begin
        focus_nxt = focus_on;
        idx_nxt   = focus_idx;
        fwd       = 1'b0;
        if (accept) begin
            if (sel_hit) begin
                if ({1'b0, sel_idx} < NF3) begin
                    focus_nxt = 1'b1;
                    idx_nxt   = sel_idx;
                end
            end else if (data == K_TAB) begin
                focus_nxt = 1'b1;
                idx_nxt   = (!focus_on || focus_idx == LAST_IDX) ? 2'd0 : focus_idx + 2'd1;
            end else if (data == K_ESC) begin
                focus_nxt = 1'b0;
            end else begin
                fwd = focus_on;
            end
        end else if (expire) begin
            focus_nxt = 1'b0;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] idle_cnt;

            assign expire = focus_on && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

            // Idle counter: parked at 0 without focus, restarted by every accepted make.
            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset)                          idle_cnt <= '0;
                else if (!focus_on || accept || expire) idle_cnt <= '0;
                else                                  idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    // Decoder, focus and output registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= ST_IDLE;
            focus_on  <= 1'b0;
            focus_idx <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            focus_on  <= focus_nxt;
            focus_idx <= idx_nxt;
            out_valid <= fwd;
            if (fwd) out_data <= data;
        end
    end

    assign field_en    = focus_on ? (NUM_FIELDS'(1) << focus_idx) : '0;
    assign focus_valid = focus_on;

endmodule

// File: doc/ps2_focus_router.md
# ps2_focus_router

Routes the shared PS/2 scancode stream to exactly one of up to four keypad-entry FSMs (loop count, tempo, pattern, and similar). It sits between the PS/2 receiver and the entry FSMs and owns keyboard focus. It decodes make, break and extended sequences, and handles focus-select keys itself. Only clean make codes reach the focused FSM, and it drives that FSM's `Enable`.

## Interface
- `NUM_FIELDS`, 4: number of entry FSMs; legal range 1..4.
- `TIMEOUT_CYCLES`, 0: idle cycles before focus is dropped automatically; 0 disables the timeout.
- `Clock` input 1: system clock; all state changes on the rising edge.
- `nReset` input 1: asynchronous, active-low reset.
- `data` input 8: scancode byte from the PS/2 receiver.
- `data_en` input 1: one-cycle strobe; `data` is valid this cycle.
- `out_data` output 8: forwarded make code; reset 8'h00; holds its value between strobes.
- `out_valid` output 1: one-cycle strobe for `out_data`; reset 0.
- `field_en` output NUM_FIELDS: one-hot `Enable` for each entry FSM, or all zero; reset 0.
- `focus_valid` output 1: equals `|field_en`; reset 0.

## Operation
- Decoder FSM, advanced only on `data_en`:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code.
  - BRK: any byte is the break code of that key -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is an extended make, discarded -> IDLE.
  - EXT_BRK: any byte is an extended break, discarded -> IDLE.
- Make codes are classified in priority order:
  - F1/F2/F3/F4 (8'h05/8'h06/8'h04/8'h0C) select field 0/1/2/3. An index >= NUM_FIELDS is ignored. Selecting the field that already has focus changes nothing.
  - TAB (8'h0D) moves focus to (idx+1) mod NUM_FIELDS. With no focus, TAB selects field 0.
  - ESC (8'h76) clears focus.
  - Any other make code is forwarded when a field has focus and dropped otherwise.
- Focus keys, break sequences and extended sequences are never forwarded. Downstream FSMs therefore only ever see make codes.
- An "accepted make" is any make code that is classified, whether it ends up forwarded, used as a focus key, or dropped. Exception: a make removed by the repeat filter is not accepted.
- Timeout, when TIMEOUT_CYCLES > 0:
  - The counter is held at 0 while there is no focus.
  - The counter clears on every accepted make.
  - Otherwise it increments each cycle while focused.
  - When the count reaches TIMEOUT_CYCLES-1, the next edge clears focus and the counter.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- If an accepted make and timeout expiry fall on the same cycle, the make wins. Focus and forwarding follow the make, and the counter goes to 0.
- Reset mid-sequence (e.g. in BRK or EXT) returns the decoder to IDLE, and all outputs take their reset values. The next byte is decoded from scratch.

## Timing
- `out_valid` and `out_data` are registered. They appear on the edge after the `data_en` cycle that delivered the make byte, giving 1 cycle of latency.
- `field_en` also updates on the edge after the `data_en` cycle of the focus key.
- When focus clears, `field_en` goes to 0 on that same edge. No `out_valid` is issued in that cycle.
- Back-to-back `data_en` on consecutive cycles is supported, with one byte processed per cycle and no stalls.
- Timeout: focus drops exactly TIMEOUT_CYCLES cycles after the last accepted make.

## Configuration
- `PS2_ROUTER_REPEAT_FILTER_EN` defined:
  - A `last_make` register (8 bits, reset 0, 0 meaning none) suppresses typematic repeats.
  - A make equal to `last_make` is discarded entirely: no forward, no focus action, no timeout clear.
  - A break of the key held in `last_make` clears the register.
  - A new distinct make overwrites the register.
  - As a result, holding TAB or a digit acts once.
- Not defined: the register is absent, and every make code is processed, repeats included.

## Test plan
- Focus and forward: reset, then 06 -> `field_en`=0010 on the next edge. Then 16 -> one-cycle `out_valid` with `out_data`=16. Then F0 16 -> no strobe, and `out_data` stays 16.
- No focus and TAB wrap (NUM_FIELDS=4): 16 with no focus -> no strobe. TAB -> 0001. Three more TABs -> 0010, 0100, 1000. A fourth TAB -> 0001. 76 -> 0000.
- Extended and ignored keys: focus F1, then E0 75, then E0 F0 75 -> no `out_valid`. Then 1E -> `out_data`=1E. With NUM_FIELDS=2, 0C -> `field_en` unchanged and nothing forwarded.
- Timeout (TIMEOUT_CYCLES=16): after F1 focus, idle for 16 cycles -> `field_en`=0 exactly at cycle 16. Separately, a key at cycle 15 -> focus kept and the count restarts.
- Repeat filter: focus F1, then 16, 16, 16, F0 16, 16. With the macro -> 2 forwards. Without the macro -> 4 forwards.
- Reset mid-operation: F1, F0, then pulse `nReset` -> all outputs 0. Then 05, 16 -> `field_en`=0001 and `out_data`=16. This shows no stale BRK state survives reset.
